axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single AXI4 read channel (AR/R) between the icache and the dcache refill/uncached-read ports.
//  Each cache keeps its own r_req/r_rdy/ret_valid/ret_last interface. This block arbitrates, drives AR, then steers R beats back to the winner.
//  One transaction is outstanding at a time. It sits between the two caches and the top-level AXI bridge.
// PARAMETERS
//  ID_W      4   width of arid/rid
//  IC_ID     0   arid used for icache transactions
//  DC_ID     1   arid used for dcache transactions
// PORTS
//  clk            in   1    single clock
//  rstn           in   1    synchronous, active-low reset
//  ic_r_req       in   1    icache read request; held until ic_r_rdy
//  ic_r_addr      in   32   icache start address
//  ic_r_length    in   8    icache burst length-1 (AXI arlen encoding)
//  ic_r_data_ready in  1    icache can accept a beat
//  ic_r_rdy       out  1    icache address accepted (1-cycle pulse)
//  ic_ret_valid   out  1    beat valid to icache
//  ic_ret_last    out  1    last beat to icache
//  ic_r_data      out  32   beat data to icache
//  dc_*           --   --   identical set of 8 signals for the dcache
//  arvalid/arready out/in 1;  araddr out 32;  arlen out 8;  arid out ID_W
//  arsize out 3 (fixed 3'b010);  arburst out 2 (fixed 2'b01 INCR)
//  rvalid/rready  in/out 1;  rdata in 32;  rid in ID_W;  rlast in 1
//  rresp          in   2    checked only, see err
//  err            out  1    sticky: rresp!=0 or rid mismatch seen; cleared by reset only
// BEHAVIOUR
//  FSM states: IDLE, ADDR, DATA. Reset -> IDLE.
//  Reset values: all outputs 0; last-grant pointer = IC, so the dcache wins the first tie.
//  IDLE: if any req is high, pick a winner.
//   - Only one req high: that requester wins.
//   - Both high: the requester not granted most recently wins.
//   - Latch winner's addr/length, set arid to IC_ID/DC_ID, go to ADDR next cycle.
//   - If no req is high, stay in IDLE.
//  ADDR: arvalid=1 with registered araddr/arlen/arid, held stable until arready.
//   - On arvalid&arready: winner's r_rdy=1 that same cycle (combinational), update pointer, go to DATA.
//   - The loser's req is ignored until the FSM returns to IDLE.
//  DATA: rready = winner's r_data_ready (combinational). For the winner: ret_valid=rvalid, ret_last=rlast, r_data=rdata.
//   - Loser's ret_valid/ret_last = 0; its r_data may be rdata.
//   - A beat completes on rvalid&rready. Completing beat with rlast -> IDLE next cycle.
//  Bus turnaround: arvalid is never high while in DATA. The earliest next arvalid is 2 cycles after the last beat (IDLE, then ADDR).
//  Beat count: rlast terminates the burst. A counter checks it against the latched arlen:
//   - rlast arriving on a beat other than beat arlen sets err.
//   - rlast missing on beat arlen also sets err.
//   - In both cases, data still follows rlast.
//  rid != latched arid on a completing beat -> err set; the beat is still routed to the winner.
//  Simultaneous: a req arriving in the same cycle as a burst's last beat is arbitrated in the following IDLE cycle.
//  Reset mid-transaction: returns to IDLE immediately, drops arvalid/rready. The interconnect is reset together with this block.
// STRUCTURE
//  Shared package (axi_pkg): AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, rd_state_t enum {IDLE,ADDR,DATA}.
//  One natural sub-module: rr_arb2, a 2-input round-robin picker with a 1-bit last-grant register and an update strobe.
//  Everything else is flat: FSM, AR register, beat counter, output mux.
// TESTING
//  1 ic_req only, addr=0x1c000040, len=15, arready at once, 16 beats -> one AR with arid=0, 16 ic_ret_valid, ic_ret_last on beat 16, dc outputs 0.
//  2 ic_req and dc_req both high after reset -> dc granted first (arid=1, len per dc). After dc rlast, ic is granted with no dc_req gap; order is dc, ic.
//  3 arready held low 5 cycles -> araddr/arlen/arid stable throughout; r_rdy pulses exactly once, on the arready cycle.
//  4 dc uncached read len=0, dc_r_data_ready low 3 cycles while rvalid high -> rready low 3 cycles; a single beat is delivered with ret_last=1.
//  5 rlast on beat 3 of len=7 burst, or rid=1 during an ic burst -> err rises and stays 1; FSM returns to IDLE after rlast.
//  6 rstn low during beat 5 of 16 -> next cycle arvalid=0, rready=0, all ret_valid=0, state IDLE. A new ic_req after reset is granted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-side constants and types for the read arbiter.
package axi_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_t;

  // Requester identity; also the encoding of the round-robin last-grant bit.
  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } rd_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational pick, 1-bit last-grant pointer
// updated only when the owner strobes upd_i.
module rr_arb2
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,       // [0] icache, [1] dcache
  input  logic       upd_i,
  input  rd_src_t    upd_idx_i,
  output logic       gnt_valid_o,
  output rd_src_t    gnt_idx_o
);

  rd_src_t last_q, last_d;

  // Pointer next value: remember who was actually granted.
  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = upd_idx_i;
    end
  end

  // Pointer register; reset points at icache so dcache wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= SRC_IC;
    end else begin
      last_q <= last_d;
    end
  end

  // Pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = SRC_IC;
    unique case (req_i)
      2'b01:   gnt_idx_o = SRC_IC;
      2'b10:   gnt_idx_o = SRC_DC;
      2'b11:   gnt_idx_o = (last_q == SRC_IC) ? SRC_DC : SRC_IC;
      default: gnt_idx_o = SRC_IC;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between icache and dcache. One transaction
// outstanding; AR is registered, R beats are steered to the winner.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned IC_ID = 0,
  parameter int unsigned DC_ID = 1
) (
  input  logic            clk,
  input  logic            rstn,
  // icache port
  input  logic            ic_r_req,
  input  logic [31:0]     ic_r_addr,
  input  logic [7:0]      ic_r_length,
  input  logic            ic_r_data_ready,
  output logic            ic_r_rdy,
  output logic            ic_ret_valid,
  output logic            ic_ret_last,
  output logic [31:0]     ic_r_data,
  // dcache port
  input  logic            dc_r_req,
  input  logic [31:0]     dc_r_addr,
  input  logic [7:0]      dc_r_length,
  input  logic            dc_r_data_ready,
  output logic            dc_r_rdy,
  output logic            dc_ret_valid,
  output logic            dc_ret_last,
  output logic [31:0]     dc_r_data,
  // AXI AR
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [ID_W-1:0] arid,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  // AXI R
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata,
  input  logic [ID_W-1:0] rid,
  input  logic            rlast,
  input  logic [1:0]      rresp,
  output logic            err
);

  rd_state_t       state_q, state_d;
  rd_src_t         win_q, win_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            arb_valid;
  rd_src_t         arb_idx;
  logic            arb_upd;
  logic            sel_ready;
  logic            beat_done;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       ({dc_r_req, ic_r_req}),
    .upd_i       (arb_upd),
    .upd_idx_i   (win_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // Winner's data-ready and the beat-completion condition.
  always_comb begin
    sel_ready = (win_q == SRC_DC) ? dc_r_data_ready : ic_r_data_ready;
    beat_done = (state_q == DATA) && rvalid && sel_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ADDR on any request, ADDR -> DATA on handshake,
  // DATA -> IDLE on the completing rlast beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_valid)           state_d = ADDR;
      ADDR:    if (arready)             state_d = DATA;
      DATA:    if (beat_done && rlast)  state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Outputs: AR valid in ADDR, R steering in DATA, r_rdy pulse on handshake.
  always_comb begin
    arvalid      = 1'b0;
    rready       = 1'b0;
    arb_upd      = 1'b0;
    ic_r_rdy     = 1'b0;
    dc_r_rdy     = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    ic_r_data    = '0;
    dc_r_data    = '0;
    unique case (state_q)
      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          arb_upd = 1'b1;
          if (win_q == SRC_DC) dc_r_rdy = 1'b1;
          else                 ic_r_rdy = 1'b1;
        end
      end
      DATA: begin
        rready    = sel_ready;
        ic_r_data = rdata;
        dc_r_data = rdata;
        if (win_q == SRC_DC) begin
          dc_ret_valid = rvalid;
          dc_ret_last  = rlast;
        end else begin
          ic_ret_valid = rvalid;
          ic_ret_last  = rlast;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: latch the winner's request in IDLE; count beats and
  // flag response errors, rid mismatches and misplaced/missing rlast.
  always_comb begin
    win_d    = win_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if ((state_q == IDLE) && arb_valid) begin
      win_d = arb_idx;
      cnt_d = '0;
      if (arb_idx == SRC_DC) begin
        araddr_d = dc_r_addr;
        arlen_d  = dc_r_length;
        arid_d   = ID_W'(DC_ID);
      end else begin
        araddr_d = ic_r_addr;
        arlen_d  = ic_r_length;
        arid_d   = ID_W'(IC_ID);
      end
    end
    if (beat_done) begin
      cnt_d = cnt_q + 8'd1;
      if (rresp != 2'b00)                 err_d = 1'b1;
      if (rid != arid_q)                  err_d = 1'b1;
      if (rlast != (cnt_q == arlen_q))    err_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_q    <= SRC_IC;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      win_q    <= win_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Port-level drive of registered AR fields and fixed attributes.
  always_comb begin
    araddr  = araddr_q;
    arlen   = arlen_q;
    arid    = arid_q;
    arsize  = AXI_SIZE_4B;
    arburst = AXI_BURST_INCR;
    err     = err_q;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rstn;
  logic        ic_r_req, ic_r_data_ready, ic_r_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0] ic_r_addr, ic_r_data;
  logic [7:0]  ic_r_length;
  logic        dc_r_req, dc_r_data_ready, dc_r_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0] dc_r_addr, dc_r_data;
  logic [7:0]  dc_r_length;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        err;

  int total;
  int bad;

  axi_rd_arbiter #(.ID_W(4), .IC_ID(0), .DC_ID(1)) dut (
    .clk(clk), .rstn(rstn),
    .ic_r_req(ic_r_req), .ic_r_addr(ic_r_addr), .ic_r_length(ic_r_length),
    .ic_r_data_ready(ic_r_data_ready), .ic_r_rdy(ic_r_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_r_data(ic_r_data),
    .dc_r_req(dc_r_req), .dc_r_addr(dc_r_addr), .dc_r_length(dc_r_length),
    .dc_r_data_ready(dc_r_data_ready), .dc_r_rdy(dc_r_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_r_data(dc_r_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arid(arid), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rlast(rlast), .rresp(rresp), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    ic_r_req = 0; ic_r_addr = '0; ic_r_length = '0; ic_r_data_ready = 0;
    dc_r_req = 0; dc_r_addr = '0; dc_r_length = '0; dc_r_data_ready = 0;
    arready = 0; rvalid = 0; rdata = '0; rid = '0; rlast = 0; rresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic drive_r(input logic v, input logic [31:0] d, input logic l,
                         input logic [3:0] id);
    rvalid = v; rdata = d; rlast = l; rid = id; rresp = 2'b00;
  endtask

  // Waits (bounded) until arvalid is seen at a sampling point; returns at negedge+1.
  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (arvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({arvalid, rready, ic_r_rdy, dc_r_rdy, ic_ret_valid, dc_ret_valid,
         ic_ret_last, dc_ret_last, err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {arvalid, rready, ic_r_rdy, dc_r_rdy, ic_ret_valid, dc_ret_valid,
                ic_ret_last, dc_ret_last, err});
    end
    total++;
    if ({araddr, arlen, arid, ic_r_data, dc_r_data} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h/%h/%h want 0", araddr, arlen, arid);
    end
    total++;
    if (arsize !== 3'b010 || arburst !== 2'b01) begin
      bad++;
      $display("FAIL fixed_attr: got size=%b burst=%b want 010/01", arsize, arburst);
    end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_single_ic();
    bit ok;
    int nvalid;
    @(negedge clk);
    ic_r_req = 1; ic_r_addr = 32'h1c00_0040; ic_r_length = 8'd15;
    ic_r_data_ready = 1; arready = 1;
    wait_ar(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_ar_timeout: got none want arvalid"); end
    total++;
    if ({araddr, arlen, arid} !== {32'h1c00_0040, 8'd15, 4'd0}) begin
      bad++;
      $display("FAIL single_ar: got %h/%h/%h want 1c000040/0f/0", araddr, arlen, arid);
    end
    total++;
    if ({ic_r_rdy, dc_r_rdy} !== 2'b10) begin
      bad++;
      $display("FAIL single_rdy: got %b want 10", {ic_r_rdy, dc_r_rdy});
    end
    nvalid = 0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      ic_r_req = 0; arready = 0;
      drive_r(1, 32'ha000_0000 + b, (b == 15), 4'd0);
      #1;
      if (ic_ret_valid === 1'b1) nvalid++;
      total++;
      if (ic_r_data !== 32'ha000_0000 + b || ic_ret_last !== (b == 15) || rready !== 1'b1) begin
        bad++;
        $display("FAIL single_beat%0d: got %h last=%b rr=%b want %h last=%b rr=1",
                 b, ic_r_data, ic_ret_last, rready, 32'ha000_0000 + b, (b == 15));
      end
      total++;
      if ({dc_ret_valid, dc_ret_last, arvalid} !== 3'b000) begin
        bad++;
        $display("FAIL single_quiet%0d: got %b want 000", b, {dc_ret_valid, dc_ret_last, arvalid});
      end
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if (nvalid != 16) begin bad++; $display("FAIL single_count: got %0d want 16", nvalid); end
    total++;
    if ({arvalid, rready, ic_ret_valid, err} !== 4'b0000) begin
      bad++;
      $display("FAIL single_idle: got %b want 0000", {arvalid, rready, ic_ret_valid, err});
    end
  endtask

  task automatic test_tie_order();
    bit ok;
    do_reset();
    ic_r_req = 1; ic_r_addr = 32'h1c00_0080; ic_r_length = 8'd0;
    dc_r_req = 1; dc_r_addr = 32'h2000_0100; dc_r_length = 8'd1;
    ic_r_data_ready = 1; dc_r_data_ready = 1; arready = 1;
    wait_ar(ok);
    total++;
    if (!ok || {araddr, arlen, arid, dc_r_rdy, ic_r_rdy} !== {32'h2000_0100, 8'd1, 4'd1, 2'b10}) begin
      bad++;
      $display("FAIL tie_first_dc: got %h/%h/%h rdy=%b%b want 20000100/01/1 rdy=10",
               araddr, arlen, arid, dc_r_rdy, ic_r_rdy);
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      dc_r_req = (b == 1);
      drive_r(1, 32'hd000_0000 + b, (b == 1), 4'd1);
      #1;
      total++;
      if ({dc_ret_valid, ic_ret_valid, arvalid, dc_ret_last} !== {3'b100, (b == 1)}) begin
        bad++;
        $display("FAIL tie_dc_beat%0d: got %b want 100%b", b,
                 {dc_ret_valid, ic_ret_valid, arvalid, dc_ret_last}, (b == 1));
      end
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if (arvalid !== 1'b0) begin bad++; $display("FAIL tie_gap: got %b want 0", arvalid); end
    @(negedge clk);
    #1;
    total++;
    if ({arvalid, arid, araddr, ic_r_rdy, dc_r_rdy} !== {1'b1, 4'd0, 32'h1c00_0080, 2'b10}) begin
      bad++;
      $display("FAIL tie_second_ic: got v=%b id=%h a=%h rdy=%b%b want v=1 id=0 a=1c000080 rdy=10",
               arvalid, arid, araddr, ic_r_rdy, dc_r_rdy);
    end
    @(negedge clk);
    ic_r_req = 0;
    drive_r(1, 32'h1111_2222, 1, 4'd0);
    #1;
    total++;
    if ({ic_ret_valid, ic_ret_last, dc_ret_valid, ic_r_data} !== {3'b110, 32'h1111_2222}) begin
      bad++;
      $display("FAIL tie_ic_beat: got %b%b%b %h want 110 11112222",
               ic_ret_valid, ic_ret_last, dc_ret_valid, ic_r_data);
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    @(negedge clk);
    #1;
    total++;
    if ({arvalid, arid, dc_r_rdy} !== {1'b1, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL tie_third_dc: got v=%b id=%h rdy=%b want 1/1/1", arvalid, arid, dc_r_rdy);
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      dc_r_req = 0;
      drive_r(1, 32'h0, (b == 1), 4'd1);
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if ({arvalid, err} !== 2'b00) begin bad++; $display("FAIL tie_end: got %b want 00", {arvalid, err}); end
  endtask

  task automatic test_arready_stall();
    bit ok;
    int pulses;
    pulses = 0;
    @(negedge clk);
    ic_r_req = 1; ic_r_addr = 32'h1c00_0200; ic_r_length = 8'd3;
    ic_r_data_ready = 1; arready = 0;
    wait_ar(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_ar_timeout: got none want arvalid"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (ic_r_rdy === 1'b1) pulses++;
      total++;
      if ({arvalid, araddr, arlen, arid} !== {1'b1, 32'h1c00_0200, 8'd3, 4'd0}) begin
        bad++;
        $display("FAIL stall_hold%0d: got %b/%h/%h/%h want 1/1c000200/03/0",
                 i, arvalid, araddr, arlen, arid);
      end
    end
    @(negedge clk);
    arready = 1;
    #1;
    if (ic_r_rdy === 1'b1) pulses++;
    total++;
    if (ic_r_rdy !== 1'b1) begin bad++; $display("FAIL stall_rdy: got %b want 1", ic_r_rdy); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      ic_r_req = 0; arready = 0;
      drive_r(1, 32'hb000_0000 + b, (b == 3), 4'd0);
      #1;
      if (ic_r_rdy === 1'b1) pulses++;
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if (pulses != 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_dc_uncached();
    bit ok;
    @(negedge clk);
    dc_r_req = 1; dc_r_addr = 32'h8000_0010; dc_r_length = 8'd0;
    dc_r_data_ready = 0; arready = 1;
    wait_ar(ok);
    total++;
    if (!ok || dc_r_rdy !== 1'b1 || arid !== 4'd1) begin
      bad++;
      $display("FAIL unc_ar: got ok=%b rdy=%b id=%h want 1/1/1", ok, dc_r_rdy, arid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dc_r_req = 0; arready = 0;
      drive_r(1, 32'hdead_beef, 1, 4'd1);
      #1;
      total++;
      if (rready !== 1'b0) begin bad++; $display("FAIL unc_stall%0d: got rready=%b want 0", i, rready); end
    end
    @(negedge clk);
    dc_r_data_ready = 1;
    #1;
    total++;
    if ({rready, dc_ret_valid, dc_ret_last, dc_r_data} !== {3'b111, 32'hdead_beef}) begin
      bad++;
      $display("FAIL unc_beat: got %b%b%b %h want 111 deadbeef",
               rready, dc_ret_valid, dc_ret_last, dc_r_data);
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if ({arvalid, rready, err} !== 3'b000) begin
      bad++;
      $display("FAIL unc_idle: got %b want 000", {arvalid, rready, err});
    end
  endtask

  task automatic test_early_rlast();
    bit ok;
    @(negedge clk);
    ic_r_req = 1; ic_r_addr = 32'h1c00_0300; ic_r_length = 8'd7;
    ic_r_data_ready = 1; arready = 1;
    wait_ar(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL early_ar_timeout: got none want arvalid"); end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      ic_r_req = 0; arready = 0;
      drive_r(1, 32'hc000_0000 + b, (b == 2), 4'd0);
      #1;
      total++;
      if ({err, ic_ret_valid} !== 2'b01) begin
        bad++;
        $display("FAIL early_beat%0d: got err=%b v=%b want 0/1", b, err, ic_ret_valid);
      end
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if ({err, arvalid, rready} !== 3'b100) begin
      bad++;
      $display("FAIL early_err: got %b want 100", {err, arvalid, rready});
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL early_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    ic_r_req = 1; ic_r_addr = 32'h1c00_0400; ic_r_length = 8'd15;
    ic_r_data_ready = 1; arready = 1;
    wait_ar(ok);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      ic_r_req = 0; arready = 0;
      drive_r(1, 32'he000_0000 + b, 0, 4'd0);
    end
    @(negedge clk);
    drive_r(1, 32'he000_0004, 0, 4'd0);
    rstn = 0;
    @(negedge clk);
    #1;
    total++;
    if ({ok, arvalid, rready, ic_ret_valid, dc_ret_valid, err} !== 6'b100000) begin
      bad++;
      $display("FAIL rstmid_idle: got %b want 100000",
               {ok, arvalid, rready, ic_ret_valid, dc_ret_valid, err});
    end
    rstn = 1;
    drive_r(0, '0, 0, '0);
    ic_r_req = 1; ic_r_addr = 32'h1c00_0500; ic_r_length = 8'd0; arready = 1;
    @(negedge clk);
    wait_ar(ok);
    total++;
    if (!ok || {araddr, arid, ic_r_rdy} !== {32'h1c00_0500, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_regrant: got ok=%b a=%h id=%h rdy=%b want 1/1c000500/0/1",
               ok, araddr, arid, ic_r_rdy);
    end
    @(negedge clk);
    ic_r_req = 0; arready = 0;
    drive_r(1, 32'h5, 1, 4'd0);
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if ({arvalid, err} !== 2'b00) begin bad++; $display("FAIL rstmid_done: got %b want 00", {arvalid, err}); end
  endtask

  task automatic test_rid_mismatch();
    bit ok;
    @(negedge clk);
    ic_r_req = 1; ic_r_addr = 32'h1c00_0600; ic_r_length = 8'd1;
    ic_r_data_ready = 1; arready = 1;
    wait_ar(ok);
    @(negedge clk);
    ic_r_req = 0; arready = 0;
    drive_r(1, 32'h1234_5678, 0, 4'd1);
    #1;
    total++;
    if ({ok, ic_ret_valid, dc_ret_valid, ic_r_data, err} !== {3'b110, 32'h1234_5678, 1'b0}) begin
      bad++;
      $display("FAIL rid_route: got ok=%b ic=%b dc=%b d=%h err=%b want 1/1/0/12345678/0",
               ok, ic_ret_valid, dc_ret_valid, ic_r_data, err);
    end
    @(negedge clk);
    drive_r(1, 32'h0, 1, 4'd0);
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if ({err, arvalid} !== 2'b10) begin bad++; $display("FAIL rid_err: got %b want 10", {err, arvalid}); end
  endtask

  task automatic test_missing_rlast();
    bit ok;
    do_reset();
    ic_r_req = 1; ic_r_addr = 32'h1c00_0700; ic_r_length = 8'd1;
    ic_r_data_ready = 1; arready = 1;
    wait_ar(ok);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      ic_r_req = 0; arready = 0;
      drive_r(1, 32'hf000_0000 + b, (b == 2), 4'd0);
      #1;
      total++;
      if ({ok, ic_ret_valid, rready} !== 3'b111) begin
        bad++;
        $display("FAIL norlast_beat%0d: got %b want 111", b, {ok, ic_ret_valid, rready});
      end
    end
    @(negedge clk);
    drive_r(0, '0, 0, '0);
    #1;
    total++;
    if ({err, arvalid, rready} !== 3'b100) begin
      bad++;
      $display("FAIL norlast_err: got %b want 100", {err, arvalid, rready});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 0;
    clear_inputs();
    test_reset();
    test_single_ic();
    test_tie_order();
    test_arready_stall();
    test_dc_uncached();
    test_early_rlast();
    test_reset_mid();
    test_rid_mismatch();
    test_missing_rlast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
